// File: rtl/counter_capture_pkg.sv
// Shared definitions for the counter_capture block: default parameters,
// entry/level width helpers and the polarity encoding of stored entries.
// Optional feature macro: COUNTER_CAPTURE_BOTH_EDGES_EN (adds a polarity bit).
package counter_capture_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
  localparam int EDGE_BITS = 1;
`else
  localparam int EDGE_BITS = 0;
`endif

  // Polarity bit stored with each entry when both edges are captured.
  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_pol_e;

  // Stored entry width: the timestamp plus the optional polarity bit.
  function automatic int entry_width(input int width);
    return width + EDGE_BITS;
  endfunction

  // Level must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/counter_capture_fifo.sv
// First-word fall-through FIFO used by counter_capture.
// head always shows the oldest entry; a push onto a full FIFO is accepted
// only when a pop happens at the same edge, otherwise it is dropped and
// flagged on drop for that cycle.
module counter_capture_fifo
  import counter_capture_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DW-1:0]                 push_data,
  input  logic                          pop,
  output logic [DW-1:0]                 head,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          empty,
  output logic                          drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign head  = mem[rd_ptr];
  assign level = count;

  // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the tail.
  // NOTE: storage is reset because head is a visible output that must read 0
  // out of reset; this keeps the array in flops, which suits a handful of entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/counter_capture.sv
// Timestamp capture: synchronises an asynchronous event, detects its edges
// and writes the current upstream count into a small FWFT FIFO read with
// valid/ready. A sticky overflow flag records dropped captures.
// Optional feature macro: COUNTER_CAPTURE_BOTH_EDGES_EN -- falling edges are
// captured too and each entry carries its polarity on o_edge.
module counter_capture
  import counter_capture_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [WIDTH-1:0]              i_count,
  input  logic                          i_event,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                          o_overflow,
  input  logic                          i_clear_ovf
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
  ,
  output logic                          o_edge
`endif
);

  localparam int EW = entry_width(WIDTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ev_s;
  logic                   ev_d;
  logic                   rise;
  logic                   capture;
  logic [EW-1:0]          wr_data;
  logic [EW-1:0]          head;
  logic                   empty;
  logic                   drop;
  logic                   ovf_q;

  // Synchroniser chain plus edge-history flop; a level already high at reset
  // release looks like a rise because everything starts at 0.
  // NOTE: non-blocking assignments make every stage take its neighbour's
  // pre-edge value, which is what turns this into a shift chain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      ev_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_event};
      ev_d   <= ev_s;
    end
  end

  assign ev_s = sync_q[SYNC_STAGES-1];
  assign rise = ev_s & ~ev_d;

`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
  logic      fall;
  edge_pol_e pol;

  assign fall    = ~ev_s & ev_d;
  assign pol     = rise ? EDGE_RISE : EDGE_FALL;
  assign capture = rise | fall;
  assign wr_data = {pol, i_count};
  assign o_edge  = head[WIDTH];
`else
  assign capture = rise;
  assign wr_data = i_count;
`endif

  counter_capture_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .push      (capture),
    .push_data (wr_data),
    .pop       (i_ready),
    .head      (head),
    .level     (o_level),
    .empty     (empty),
    .drop      (drop)
  );

  // Sticky overflow: a drop sets it and wins over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (i_clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_overflow = ovf_q;
  assign o_valid    = ~empty;
  assign o_data     = head[WIDTH-1:0];

endmodule

// File: tb/tb_counter_capture.sv
// Directed bench for counter_capture (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
// A behavioural model built from the event latency and FIFO rules predicts
// every output; expected entries are queued as captures are predicted and
// popped as the consumer drains them.
module tb_counter_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
  localparam int EPP = 2;  // entries per event pulse
`else
  localparam int EPP = 1;
`endif

  typedef struct packed {
    logic             pol;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             i_reset_n;
  logic [WIDTH-1:0] i_count;
  logic             i_event;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic [2:0]       o_level;
  logic             o_overflow;
  logic             i_clear_ovf;
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
  logic             o_edge;
`endif

  counter_capture #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_count     (i_count),
    .i_event     (i_event),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .i_clear_ovf (i_clear_ovf)
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
    ,
    .o_edge      (o_edge)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];
  logic ovf_m;
  logic s1, s2, s3;  // i_event as sampled at the last three edges

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic check_all();
    check("valid", 32'(o_valid), 32'(exp_q.size() != 0));
    check("level", 32'(o_level), 32'(exp_q.size()));
    check("overflow", 32'(o_overflow), 32'(ovf_m));
    if (exp_q.size() != 0) begin
      check("data", 32'(o_data), 32'(exp_q[0].data));
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
      check("edge", 32'(o_edge), 32'(exp_q[0].pol));
`endif
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ovf_m = 1'b0;
    s1 = 1'b0;
    s2 = 1'b0;
    s3 = 1'b0;
  endtask

  // Predict the effect of the coming edge, advance one clock, drive the next
  // count value and compare every output.
  task automatic step();
    logic rise_m, fall_m, full_m, pop_m;
    exp_t e;
    if (i_reset_n) begin
      rise_m = s2 & ~s3;
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
      fall_m = ~s2 & s3;
`else
      fall_m = 1'b0;
`endif
      full_m = (exp_q.size() == DEPTH);
      pop_m  = i_ready && (exp_q.size() != 0);
      if (pop_m) void'(exp_q.pop_front());
      if (i_clear_ovf) ovf_m = 1'b0;
      if (rise_m || fall_m) begin
        if (!full_m || pop_m) begin
          e.pol  = rise_m;
          e.data = i_count;
          exp_q.push_back(e);
        end else begin
          ovf_m = 1'b1;
        end
      end
      s3 = s2;
      s2 = s1;
      s1 = i_event;
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    i_count = WIDTH'(100 + edge_cnt);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Event pulse; returns the timestamp its rising edge is expected to capture.
  task automatic pulse(input int hi, input int lo, output logic [WIDTH-1:0] ts);
    ts = WIDTH'(100 + edge_cnt + 2);
    i_event = 1'b1;
    steps(hi);
    i_event = 1'b0;
    steps(lo);
  endtask

  logic [WIDTH-1:0] ts [5];
  logic [WIDTH-1:0] ts_new;

  initial begin
    i_reset_n   = 1'b0;
    i_count     = WIDTH'(100);
    i_event     = 1'b0;
    i_ready     = 1'b0;
    i_clear_ovf = 1'b0;
    model_reset();

    // Reset state held over a few edges.
    steps(3);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_data", 32'(o_data), 32'd0);
    i_reset_n = 1'b1;
    while (edge_cnt < 10) step();

    // 1: rise after edge 10, write at edge 13, count 112.
    i_event = 1'b1;
    steps(2);
    check("s1_no_bypass", 32'(o_valid), 32'd0);
    step();
    check("s1_valid", 32'(o_valid), 32'd1);
    check("s1_data", 32'(o_data), 32'd112);
    check("s1_level", 32'(o_level), 32'd1);
    check("s1_ovf", 32'(o_overflow), 32'd0);
    steps(2);
    i_event = 1'b0;
    steps(4);
    i_ready = 1'b1;
    steps(3);
    i_ready = 1'b0;
    check("s1_drained", 32'(o_level), 32'd0);

    // 2: five pulses with no reader -> full and overflow.
    for (int p = 0; p < 5; p++) pulse(3, 3, ts[p]);
    steps(3);
    check("s2_level", 32'(o_level), 32'd4);
    check("s2_ovf", 32'(o_overflow), 32'd1);
    check("s2_head", 32'(o_data), 32'(ts[0]));

    // 3: drain in capture order, then clear the overflow flag.
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifndef COUNTER_CAPTURE_BOTH_EDGES_EN
      check("s3_order", 32'(o_data), 32'(ts[i]));
`endif
      step();
    end
    i_ready = 1'b0;
    check("s3_empty", 32'(o_valid), 32'd0);
    check("s3_level", 32'(o_level), 32'd0);
    check("s3_ovf_sticky", 32'(o_overflow), 32'd1);
    i_clear_ovf = 1'b1;
    step();
    i_clear_ovf = 1'b0;
    check("s3_ovf_clear", 32'(o_overflow), 32'd0);

    // 4: full FIFO, capture and pop at the same edge.
    for (int p = 0; p < DEPTH / EPP; p++) pulse(3, 3, ts[p]);
    steps(3);
    check("s4_full", 32'(o_level), 32'd4);
    ts_new = WIDTH'(100 + edge_cnt + 2);
    i_event = 1'b1;
    steps(2);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("s4_level", 32'(o_level), 32'd4);
    check("s4_no_ovf", 32'(o_overflow), 32'd0);
    i_event = 1'b0;
    steps(3);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifndef COUNTER_CAPTURE_BOTH_EDGES_EN
      if (i == 3) check("s4_last", 32'(o_data), 32'(ts_new));
`endif
      step();
    end
    i_ready = 1'b0;
    i_clear_ovf = 1'b1;
    step();
    i_clear_ovf = 1'b0;
    step();

    // 5: asynchronous reset mid-cycle with two entries held.
    for (int p = 0; p < 2 / EPP; p++) pulse(3, 3, ts[p]);
    steps(3);
    check("s5_level2", 32'(o_level), 32'd2);
    #3;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check("s5_rst_valid", 32'(o_valid), 32'd0);
    check("s5_rst_level", 32'(o_level), 32'd0);
    check("s5_rst_ovf", 32'(o_overflow), 32'd0);
    check("s5_rst_data", 32'(o_data), 32'd0);
`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
    check("s5_rst_edge", 32'(o_edge), 32'd0);
`endif
    #2;
    i_reset_n = 1'b1;
    steps(2);
    ts_new = WIDTH'(100 + edge_cnt + 2);
    i_event = 1'b1;
    steps(3);
    check("s5_recapture_valid", 32'(o_valid), 32'd1);
    check("s5_recapture_data", 32'(o_data), 32'(ts_new));
    check("s5_recapture_level", 32'(o_level), 32'd1);
    i_event = 1'b0;
    steps(4);
    i_ready = 1'b1;
    steps(3);
    i_ready = 1'b0;

`ifdef COUNTER_CAPTURE_BOTH_EDGES_EN
    // 6: both edges captured, polarity reported, timestamps 6 apart.
    ts_new = WIDTH'(100 + edge_cnt + 2);
    i_event = 1'b1;
    steps(6);
    i_event = 1'b0;
    steps(4);
    check("s6_level", 32'(o_level), 32'd2);
    check("s6_rise_pol", 32'(o_edge), 32'd1);
    check("s6_rise_data", 32'(o_data), 32'(ts_new));
    i_ready = 1'b1;
    step();
    check("s6_fall_pol", 32'(o_edge), 32'd0);
    check("s6_fall_data", 32'(o_data), 32'(WIDTH'(ts_new + 8'd6)));
    step();
    i_ready = 1'b0;
    check("s6_empty", 32'(o_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
